// File: rtl/wb_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ext_arbiter
// Purpose  : Round-robin Wishbone B3 arbiter for the external-RAM slave port,
//            holding a grant for a whole bus cycle, with an ack watchdog.
// Revision : 1.0
// ============================================================================
module wb_ext_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 27,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [DW/8-1:0]           s_sel_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      timeout_o
);

    localparam int c_IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_SW = DW / 8;
    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [c_IW-1:0]         gidx_q, gidx_d;
    logic [c_IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [c_CW-1:0]         wd_cnt_q, wd_cnt_d;

    logic [AW-1:0]           w_adr [NUM_MASTERS];
    logic [DW-1:0]           w_dat [NUM_MASTERS];
    logic [c_SW-1:0]         w_sel [NUM_MASTERS];
    logic [2:0]              w_cti [NUM_MASTERS];
    logic [1:0]              w_bte [NUM_MASTERS];

    logic                    w_cyc, w_stb, w_resp, w_busy, w_expire;
    logic                    w_found;
    logic [c_IW-1:0]         w_pick;

    function automatic logic [c_IW-1:0] mod_idx(input logic [c_IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return c_IW'(s);
    endfunction

    generate
        for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
            assign w_adr[g] = m_adr_i[g*AW +: AW];
            assign w_dat[g] = m_dat_i[g*DW +: DW];
            assign w_sel[g] = m_sel_i[g*c_SW +: c_SW];
            assign w_cti[g] = m_cti_i[g*3 +: 3];
            assign w_bte[g] = m_bte_i[g*2 +: 2];
        end
    endgenerate

    assign s_adr_o = w_adr[gidx_q];
    assign s_dat_o = w_dat[gidx_q];
    assign s_sel_o = w_sel[gidx_q];
    assign s_we_o  = m_we_i[gidx_q];
    assign s_cti_o = w_cti[gidx_q];
    assign s_bte_o = w_bte[gidx_q];
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    assign w_cyc    = m_cyc_i[gidx_q];
    assign w_stb    = w_cyc & m_stb_i[gidx_q];
    assign w_resp   = s_ack_i | s_err_i | s_rty_i;
    assign w_busy   = (state_q == S_BUSY);
    // A response in the expiry cycle wins over the watchdog.
    assign w_expire = w_busy & w_stb & ~w_resp & (wd_cnt_q == c_CW'(TIMEOUT - 1));

    // Scan from the highest offset down so the nearest requester to rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = rr_ptr_q;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_cyc_i[mod_idx(rr_ptr_q, i)]) begin
                w_found = 1'b1;
                w_pick  = mod_idx(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        wd_cnt_d  = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rty_o   = '0;
        timeout_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (w_found) begin
                    state_d         = S_BUSY;
                    gidx_d          = w_pick;
                    grant_d[w_pick] = 1'b1;
                end
            end
            S_BUSY: begin
                s_cyc_o         = w_cyc & ~w_expire;
                s_stb_o         = w_stb & ~w_expire;
                m_ack_o[gidx_q] = s_ack_i;
                m_err_o[gidx_q] = s_err_i | w_expire;
                m_rty_o[gidx_q] = s_rty_i;
                timeout_o       = w_expire;
                if (!w_cyc) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = mod_idx(gidx_q, 1);
                end else if (w_expire) begin
                    state_d = S_ABORT;
                end else if (w_stb && !w_resp) begin
                    wd_cnt_d = wd_cnt_q + c_CW'(1);
                end
            end
            S_ABORT: begin
                if (!w_cyc) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = mod_idx(gidx_q, 1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_ext_arbiter
// Purpose  : Randomized bench for wb_ext_arbiter against a cycle-level model.
// Revision : 1.0
// ============================================================================
module tb_wb_ext_arbiter;

    localparam int N     = 2;
    localparam int AW    = 27;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int TO    = 16;
    localparam int NCYC  = 8000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N*SW-1:0]   m_sel;
    logic [N-1:0]      m_we, m_cyc, m_stb;
    logic [N*3-1:0]    m_cti;
    logic [N*2-1:0]    m_bte;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o, s_dat;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic              s_ack, s_err, s_rty;

    logic [AW-1:0]     b_adr [N];
    logic [DW-1:0]     b_dat [N];
    logic [SW-1:0]     b_sel [N];
    logic [2:0]        b_cti [N];
    logic [1:0]        b_bte [N];
    logic              b_we  [N];
    logic              b_cyc [N];
    logic              b_stb [N];
    int                beats [N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_ext_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always_comb begin
        m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
        m_we  = '0; m_cyc = '0; m_stb = '0;
        for (int i = 0; i < N; i++) begin
            m_adr[i*AW +: AW] = b_adr[i];
            m_dat[i*DW +: DW] = b_dat[i];
            m_sel[i*SW +: SW] = b_sel[i];
            m_cti[i*3 +: 3]   = b_cti[i];
            m_bte[i*2 +: 2]   = b_bte[i];
            m_we[i]           = b_we[i];
            m_cyc[i]          = b_cyc[i];
            m_stb[i]          = b_stb[i];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: owner index (-1 = free), abort flag, rotation start, stall count.
    int own, rr, stall;
    bit ab;
    int n_own, n_rr, n_stall;
    bit n_ab;
    logic [N-1:0] obs_ack, obs_err, obs_rty;
    int mode;

    initial begin
        logic [N-1:0] e_grant, e_ack, e_err, e_rty;
        logic e_scyc, e_sstb, e_to;
        bit c, st, resp, fire;

        rst = 1'b1;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
        for (int m = 0; m < N; m++) begin
            b_adr[m] = '0; b_dat[m] = '0; b_sel[m] = '0; b_cti[m] = '0;
            b_bte[m] = '0; b_we[m] = 1'b0; b_cyc[m] = 1'b0; b_stb[m] = 1'b0;
            beats[m] = 0;
        end
        own = -1; rr = 0; stall = 0; ab = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc_n = 0; cyc_n < NCYC; cyc_n++) begin
            @(negedge clk);
            e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
            e_scyc = 1'b0; e_sstb = 1'b0; e_to = 1'b0;
            n_own = own; n_rr = rr; n_stall = 0; n_ab = ab;
            if (own < 0) begin
                for (int k = 0; k < N; k++)
                    if (n_own < 0 && b_cyc[(rr + k) % N]) n_own = (rr + k) % N;
                n_ab = 1'b0;
            end else begin
                e_grant[own] = 1'b1;
                c = b_cyc[own];
                if (!ab) begin
                    st   = c && b_stb[own];
                    resp = s_ack || s_err || s_rty;
                    fire = st && !resp && (stall == TO - 1);
                    e_scyc = c && !fire;
                    e_sstb = st && !fire;
                    e_ack[own] = s_ack;
                    e_err[own] = s_err || fire;
                    e_rty[own] = s_rty;
                    e_to = fire;
                    if (!c) begin
                        n_own = -1; n_rr = (own + 1) % N;
                    end else if (fire) begin
                        n_ab = 1'b1;
                    end else if (st && !resp) begin
                        n_stall = stall + 1;
                    end
                end else if (!c) begin
                    n_own = -1; n_rr = (own + 1) % N; n_ab = 1'b0;
                end
            end

            check_val("grant",   64'(grant_o),   64'(e_grant));
            check_val("s_cyc",   64'(s_cyc_o),   64'(e_scyc));
            check_val("s_stb",   64'(s_stb_o),   64'(e_sstb));
            check_val("m_ack",   64'(m_ack_o),   64'(e_ack));
            check_val("m_err",   64'(m_err_o),   64'(e_err));
            check_val("m_rty",   64'(m_rty_o),   64'(e_rty));
            check_val("timeout", 64'(timeout_o), 64'(e_to));
            check_val("m_dat",   64'(m_dat_o),   64'(s_dat));
            if (own >= 0) begin
                check_val("s_adr", 64'(s_adr_o), 64'(b_adr[own]));
                check_val("s_dat", 64'(s_dat_o), 64'(b_dat[own]));
                check_val("s_sel", 64'(s_sel_o), 64'(b_sel[own]));
                check_val("s_we",  64'(s_we_o),  64'(b_we[own]));
                check_val("s_cti", 64'(s_cti_o), 64'(b_cti[own]));
                check_val("s_bte", 64'(s_bte_o), 64'(b_bte[own]));
            end
            obs_ack = m_ack_o; obs_err = m_err_o; obs_rty = m_rty_o;

            @(posedge clk);
            if (rst) begin
                own = -1; rr = 0; stall = 0; ab = 1'b0;
            end else begin
                own = n_own; rr = n_rr; stall = n_stall; ab = n_ab;
            end
            #1;
            rst = ($urandom % 400 == 0);
            if ($urandom % 150 == 0) mode = int'($urandom % 3);

            for (int m = 0; m < N; m++) begin
                if (b_cyc[m]) begin
                    if (obs_err[m] || ($urandom % 64 == 0)) begin
                        b_cyc[m] = 1'b0; b_stb[m] = 1'b0;
                    end else if (obs_ack[m] || obs_rty[m]) begin
                        if (obs_ack[m]) beats[m]--;
                        if (beats[m] <= 0) begin
                            b_cyc[m] = 1'b0; b_stb[m] = 1'b0;
                        end else begin
                            b_adr[m] = b_adr[m] + AW'(4);
                            b_dat[m] = $urandom;
                            b_cti[m] = (beats[m] == 1) ? 3'b111 : 3'b010;
                            b_stb[m] = 1'b1;
                        end
                    end else begin
                        b_stb[m] = ($urandom % 8 != 0);
                    end
                end else if ($urandom % 4 == 0) begin
                    beats[m] = 1 + int'($urandom % 4);
                    b_cyc[m] = 1'b1;
                    b_stb[m] = 1'b1;
                    b_adr[m] = AW'($urandom);
                    b_dat[m] = $urandom;
                    b_sel[m] = SW'($urandom);
                    b_we[m]  = $urandom % 2 == 0;
                    b_bte[m] = 2'($urandom);
                    b_cti[m] = (beats[m] > 1) ? 3'b010 : (($urandom % 2 == 0) ? 3'b000 : 3'b111);
                end
            end

            s_dat = $urandom;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            case (mode)
                0: begin
                    case ($urandom % 8)
                        0, 1, 2: s_ack = 1'b1;
                        3:       s_err = 1'b1;
                        4:       s_rty = 1'b1;
                        default: ;
                    endcase
                end
                2: s_ack = (own >= 0) && !ab && (stall == TO - 1);
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_ext_arbiter.md
Name: wb_ext_arbiter

Overview:
- Round-robin Wishbone B3 arbiter sharing the single external-RAM slave port (wb_ext_*) between NUM_MASTERS bus masters, e.g. the CPU data port and the OSD MAM debug master.
- Sits between the masters and the external memory interface; a grant is held for a complete bus cycle, including incrementing bursts.
- Adds a per-transfer ack watchdog, so a hung slave cannot lock out the debug master.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (2..8); index 0 has the highest priority after reset.
- AW, 27: address width, equal to MEM_ADDR_WIDTH for 128 MiB.
- DW, 32: data width; select width is DW/8.
- TIMEOUT, 1024: cycles a granted strobe may wait for ack/err/rty before abort (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_adr_i  in  NUM_MASTERS*AW  packed master addresses
- m_dat_i  in  NUM_MASTERS*DW  packed master write data
- m_sel_i  in  NUM_MASTERS*DW/8  byte selects
- m_we_i  in  NUM_MASTERS  write enables
- m_cyc_i  in  NUM_MASTERS  cycle requests
- m_stb_i  in  NUM_MASTERS  strobes
- m_cti_i  in  NUM_MASTERS*3  cycle type identifiers
- m_bte_i  in  NUM_MASTERS*2  burst type extensions
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master error
- m_rty_o  out  NUM_MASTERS  per-master retry
- s_adr_o  out  AW  to slave
- s_dat_o  out  DW  to slave
- s_sel_o  out  DW/8  to slave
- s_we_o  out  1  to slave
- s_cyc_o  out  1  to slave
- s_stb_o  out  1  to slave
- s_cti_o  out  3  to slave
- s_bte_o  out  2  to slave
- s_dat_i  in  DW  from slave
- s_ack_i  in  1  from slave
- s_err_i  in  1  from slave
- s_rty_i  in  1  from slave
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- On reset: state IDLE, grant_o=0, rr_ptr=0, wd_cnt=0, timeout_o=0.
- Reset taken mid-burst returns the block to IDLE on the next cycle with s_cyc_o=0; no ack is generated for the aborted beat.
- States and transitions:
  - IDLE: s_cyc_o=s_stb_o=0, all m_ack/err/rty=0. If any m_cyc_i is set, register a grant to the first requester found searching rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS; go to BUSY. Arbitration latency is 1 cycle: cyc at edge N, s_cyc_o at N+1.
  - BUSY: all s_* outputs are combinationally muxed from the granted master.
    - s_ack/err/rty_i are routed only to the granted master's m_*_o; other masters see 0. m_dat_o=s_dat_i always.
    - When the granted m_cyc_i drops, s_cyc_o/s_stb_o drop in the same cycle (gated). Next state IDLE, rr_ptr := granted index+1 (mod NUM_MASTERS).
    - The grant is not released on a cti=3'b111 end-of-burst beat. Release depends only on cyc, so classic back-to-back cycles under one cyc stay owned.
  - ABORT: entered on watchdog expiry. s_cyc_o=s_stb_o=0. Wait for the granted m_cyc_i to drop, then go to IDLE and rotate rr_ptr as above.
- Watchdog:
  - wd_cnt counts cycles in BUSY with s_stb_o=1 and none of ack/err/rty.
  - Cleared on any ack/err/rty, and whenever stb is low.
  - When wd_cnt==TIMEOUT-1 with still no response: assert m_err_o[grant] and timeout_o for exactly that cycle, force s_cyc_o=0 that cycle, go to ABORT.
  - A slave ack arriving in the same cycle as expiry wins: normal ack, no timeout.
- A new requester arriving while BUSY waits; there is no preemption.
- Simultaneous requests in IDLE are resolved strictly by rr_ptr order.
- A master that drops and immediately reasserts cyc competes again from IDLE. It loses to any other pending requester because rr_ptr has rotated past it.
- grant_o is a registered, one-hot copy of the owner. It is 0 in IDLE and keeps the owner's bit in ABORT.

Test Plan:
- Reset, then m_cyc_i=2'b01 with stb, single write adr=0x100, slave acks 2 cycles later -> s_cyc_o rises 1 cycle after m_cyc_i; m_ack_o=2'b01 for exactly 1 cycle; grant_o returns to 0 the cycle after cyc drops.
- Both masters request in the same cycle after reset -> master 0 granted first. After master 0 releases, master 1 is granted 1 cycle later; the next simultaneous request goes to master 0 again (rr_ptr=0 after master 1).
- Master 1 runs a 4-beat incrementing burst (cti 010,010,010,111) while master 0 requests at beat 2 -> all 4 beats are forwarded to master 1 with no interleaving; master 0 is granted only after master 1 drops cyc.
- Slave never acks, TIMEOUT=16 -> timeout_o and m_err_o[granted] pulse on the 16th stalled cycle; s_cyc_o is low from that cycle on; the next requester is granted after the aborted master drops cyc.
- Slave ack in exactly the expiry cycle -> m_ack_o asserted, m_err_o=0, timeout_o=0, state stays BUSY.
- Assert rst during beat 2 of a burst -> s_cyc_o=0 and grant_o=0 on the next edge; no m_ack_o; a fresh request from master 1 is then granted with rr_ptr=0 priority rules.
